// File: rtl/matprod_stage_sequencer.sv
// Runs the enabled matprod sub-blocks in order over ap_ctrl_hs, with per-stage/total cycle counters and a watchdog.
// Stage handoff is bubble-free; ap_done holds until ap_continue, and ap_start is only accepted in IDLE.
module matprod_stage_sequencer #(
    parameter int NUM_STAGES     = 4,
    parameter int CNT_W          = 32,
    parameter int TIMEOUT_CYCLES = 0,
    localparam int IDX_W         = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
    input  logic                        ap_clk,
    input  logic                        ap_rst,
    input  logic                        ap_start,
    input  logic [NUM_STAGES-1:0]       stage_mask,
    input  logic                        ap_continue,
    output logic                        ap_idle,
    output logic                        ap_ready,
    output logic                        ap_done,
    output logic [NUM_STAGES-1:0]       stage_start,
    input  logic [NUM_STAGES-1:0]       stage_done,
    output logic [NUM_STAGES*CNT_W-1:0] stage_cycles,
    output logic [CNT_W-1:0]            total_cycles,
    output logic                        error,
    output logic [IDX_W-1:0]            err_stage
);

    localparam logic [1:0]       S_IDLE   = 2'd0;
    localparam logic [1:0]       S_RUN    = 2'd1;
    localparam logic [1:0]       S_DONE   = 2'd2;
    localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [1:0]            r_state;
    logic [NUM_STAGES-1:0] r_mask;
    logic [NUM_STAGES-1:0] r_stage_start;
    logic [IDX_W-1:0]      r_idx;
    logic [IDX_W-1:0]      r_err_stage;
    logic                  r_ready;
    logic                  r_error;
    logic [CNT_W-1:0]      r_cycles [NUM_STAGES];
    logic [CNT_W-1:0]      r_total;

    logic [IDX_W-1:0]      w_first_idx;
    logic [IDX_W-1:0]      w_next_idx;
    logic                  w_first_vld;
    logic                  w_next_vld;
    logic                  w_cur_done;
    logic                  w_timeout;
    logic [CNT_W-1:0]      w_cur_cnt_nxt;
    logic [CNT_W-1:0]      w_total_nxt;

    function automatic logic [NUM_STAGES-1:0] f_onehot(input logic [IDX_W-1:0] idx);
        f_onehot      = '0;
        f_onehot[idx] = 1'b1;
    endfunction

    // Descending scan so the last hit is the lowest qualifying index.
    always_comb begin
        w_first_idx = '0;
        w_first_vld = 1'b0;
        w_next_idx  = '0;
        w_next_vld  = 1'b0;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            if (stage_mask[i]) begin
                w_first_idx = IDX_W'(i);
                w_first_vld = 1'b1;
            end
            if (r_mask[i] && (i > int'(r_idx))) begin
                w_next_idx = IDX_W'(i);
                w_next_vld = 1'b1;
            end
        end
    end

    assign w_cur_done    = stage_done[r_idx];
    assign w_cur_cnt_nxt = (r_cycles[r_idx] == CNT_MAX) ? CNT_MAX : r_cycles[r_idx] + 1'b1;
    assign w_total_nxt   = (r_total == CNT_MAX) ? CNT_MAX : r_total + 1'b1;
    // A done arriving on the limit cycle takes priority over the abort.
    assign w_timeout     = (TIMEOUT_CYCLES != 0) && (w_cur_cnt_nxt >= TO_LIMIT) && !w_cur_done;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_state       <= S_IDLE;
            r_mask        <= '0;
            r_stage_start <= '0;
            r_idx         <= '0;
            r_err_stage   <= '0;
            r_ready       <= 1'b0;
            r_error       <= 1'b0;
            r_total       <= '0;
            for (int i = 0; i < NUM_STAGES; i++) begin
                r_cycles[i] <= '0;
            end
        end else begin
            r_ready <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (ap_start) begin
                        r_ready     <= 1'b1;
                        r_mask      <= stage_mask;
                        r_error     <= 1'b0;
                        r_err_stage <= '0;
                        r_total     <= '0;
                        for (int i = 0; i < NUM_STAGES; i++) begin
                            r_cycles[i] <= '0;
                        end
                        if (w_first_vld) begin
                            r_state       <= S_RUN;
                            r_idx         <= w_first_idx;
                            r_stage_start <= f_onehot(w_first_idx);
                        end else begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_RUN: begin
                    r_cycles[r_idx] <= w_cur_cnt_nxt;
                    r_total         <= w_total_nxt;
                    if (w_cur_done) begin
                        if (w_next_vld) begin
                            r_idx         <= w_next_idx;
                            r_stage_start <= f_onehot(w_next_idx);
                        end else begin
                            r_state       <= S_DONE;
                            r_stage_start <= '0;
                        end
                    end else if (w_timeout) begin
                        r_error       <= 1'b1;
                        r_err_stage   <= r_idx;
                        r_state       <= S_DONE;
                        r_stage_start <= '0;
                    end
                end
                S_DONE: begin
                    if (ap_continue) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state       <= S_IDLE;
                    r_stage_start <= '0;
                end
            endcase
        end
    end

    assign ap_idle      = (r_state == S_IDLE);
    assign ap_done      = (r_state == S_DONE);
    assign ap_ready     = r_ready;
    assign stage_start  = r_stage_start;
    assign total_cycles = r_total;
    assign error        = r_error;
    assign err_stage    = r_err_stage;

    for (genvar g = 0; g < NUM_STAGES; g++) begin : g_cyc
        assign stage_cycles[g*CNT_W +: CNT_W] = r_cycles[g];
    end

endmodule
